// File: rtl/game_pkg.sv
// game_pkg: shared types for the brick-game sequencer.
//   state_e   - sequencer state codes (also exported on state_out)
//   draw_op_e - op codes presented to the drawer on draw_op
//   clog2_w() - constant width helper for IDX_W / CNT_W
package game_pkg;

  typedef enum logic [3:0] {
    S_INIT, S_POPULATE, S_LOOP_RESET, S_MOVE_PADDLE, S_ERASE_PADDLE,
    S_DRAW_PADDLE, S_MOVE_BALL, S_ERASE_BALL, S_DRAW_BALL, S_COLLIDE,
    S_REMOVE_BRICK, S_LEVEL_CLEAR, S_GAME_OVER
  } state_e;

  // OP_NONE is the idle/reset value of draw_op.
  typedef enum logic [2:0] {
    OP_NONE, OP_POPULATE, OP_ERASE_PADDLE, OP_DRAW_PADDLE,
    OP_ERASE_BALL, OP_DRAW_BALL, OP_REMOVE_BRICK
  } draw_op_e;

  function automatic int clog2_w(input int n);
    int w;
    w = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < n) w = i + 1;
    return w;
  endfunction

endpackage

// File: rtl/game_sequencer_if.sv
// game_sequencer_if: draw request/complete handshake between the sequencer
// and the drawer.
//   draw_req  - high for the whole time the sequencer sits in a draw state
//   draw_op   - op code (game_pkg::draw_op_e)
//   draw_idx  - brick index for populate/remove ops, 0 otherwise
//   draw_done - one-cycle completion pulse from the drawer
// Modports: master = sequencer side, slave = drawer side.
interface game_sequencer_if #(parameter int IDX_W = 4) ();
  import game_pkg::*;

  logic             draw_req;
  draw_op_e         draw_op;
  logic [IDX_W-1:0] draw_idx;
  logic             draw_done;

  modport master (output draw_req, draw_op, draw_idx, input draw_done);
  modport slave  (input draw_req, draw_op, draw_idx, output draw_done);
endinterface

// File: rtl/brick_tracker.sv
// brick_tracker: alive bitmap plus running count of alive bricks.
//   clear_all      - wipe bitmap and count
//   set_en/clr_en  - set or clear the brick selected by idx
//   brick_alive    - alive bitmap
//   bricks_left    - number of set bits in brick_alive
// The count only moves when the addressed bit actually changes, so it
// tracks the popcount and stays within 0..NUM_BRICKS.
module brick_tracker #(
  parameter int NUM_BRICKS = 12,
  parameter int IDX_W      = 4,
  parameter int CNT_W      = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clear_all,
  input  logic                  set_en,
  input  logic                  clr_en,
  input  logic [IDX_W-1:0]      idx,
  output logic [NUM_BRICKS-1:0] brick_alive,
  output logic [CNT_W-1:0]      bricks_left
);
  localparam logic [NUM_BRICKS-1:0] ONE = NUM_BRICKS'(1);

  logic [NUM_BRICKS-1:0] sel;
  logic                  cur;

  assign sel = ONE << idx;
  assign cur = |(brick_alive & sel);

  always_ff @(posedge clk) begin
    if (reset || clear_all) begin
      brick_alive <= '0;
      bricks_left <= '0;
    end else if (set_en && !cur && bricks_left < CNT_W'(NUM_BRICKS)) begin
      brick_alive <= brick_alive | sel;
      bricks_left <= bricks_left + CNT_W'(1);
    end else if (clr_en && cur && bricks_left != '0) begin
      brick_alive <= brick_alive & ~sel;
      bricks_left <= bricks_left - CNT_W'(1);
    end
  end
endmodule

// File: rtl/game_sequencer.sv
// game_sequencer: frame-level sequencer for a brick game.
//   clk, reset     - clock, synchronous active-high reset
//   tick           - frame enable; every state advance waits for it
//   dif (master)   - draw handshake (draw_req/op/idx out, draw_done in)
//   hit_valid/hit_index, ball_lost - collision results, sampled in COLLIDE
//   move_paddle, move_ball, collide, reset_initial, reset_loop - state strobes
//   brick_alive, bricks_left, lives, game_over, state_out - status
// Build option: define GAME_SEQUENCER_LIVES_EN to make ball_lost cost a
// life and end the game at zero; otherwise ball_lost is ignored.
module game_sequencer
  import game_pkg::*;
#(
  parameter  int NUM_BRICKS  = 12,
  parameter  int START_LIVES = 3,
  localparam int IDX_W       = clog2_w(NUM_BRICKS),
  localparam int CNT_W       = clog2_w(NUM_BRICKS + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  tick,
  game_sequencer_if.master      dif,
  input  logic                  hit_valid,
  input  logic [IDX_W-1:0]      hit_index,
  input  logic                  ball_lost,
  output logic                  move_paddle,
  output logic                  move_ball,
  output logic                  collide,
  output logic                  reset_initial,
  output logic                  reset_loop,
  output logic [NUM_BRICKS-1:0] brick_alive,
  output logic [CNT_W-1:0]      bricks_left,
  output logic [3:0]            lives,
  output logic                  game_over,
  output logic [3:0]            state_out
);
  localparam logic [IDX_W-1:0]      LAST_IDX = IDX_W'(NUM_BRICKS - 1);
  localparam logic [NUM_BRICKS-1:0] ONE      = NUM_BRICKS'(1);

  state_e           state, state_n;
  logic [IDX_W-1:0] idx, idx_n;
  logic             done_q, is_draw, fire, hit_ok, lost;
  logic             set_en, clr_en, clear_all, lives_dec;

  assign is_draw = state inside {S_POPULATE, S_ERASE_PADDLE, S_DRAW_PADDLE,
                                 S_ERASE_BALL, S_DRAW_BALL, S_REMOVE_BRICK};
  assign fire    = tick & done_q;
  // Out-of-range indices shift the select bit out, but the range test
  // keeps the intent explicit.
  assign hit_ok  = hit_valid && (int'(hit_index) < NUM_BRICKS) &&
                   (|(brick_alive & (ONE << hit_index)));

`ifdef GAME_SEQUENCER_LIVES_EN
  logic [3:0] lives_q;
  always_ff @(posedge clk) begin
    if (reset)          lives_q <= 4'(START_LIVES);
    else if (lives_dec) lives_q <= lives_q - 4'd1;
  end
  assign lives     = lives_q;
  assign lost      = ball_lost;
  assign game_over = (state == S_GAME_OVER);
`else
  logic unused_lives;
  assign unused_lives = ball_lost | lives_dec;
  assign lives        = 4'(START_LIVES);
  assign lost         = 1'b0;
  assign game_over    = 1'b0;
`endif

  // Sticky completion flag: only armed inside a draw state, dropped on the
  // tick that consumes it (including POPULATE's per-brick self-loop).
  always_ff @(posedge clk) begin
    if (reset)                      done_q <= 1'b0;
    else if (!is_draw || fire)      done_q <= 1'b0;
    else if (dif.draw_done)         done_q <= 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_INIT;
      idx   <= '0;
    end else begin
      state <= state_n;
      idx   <= idx_n;
    end
  end

  // Every legal transition is gated by tick inside the case, so the
  // registers hold on non-tick cycles; the default arm recovers at once.
  always_comb begin
    state_n   = state;
    idx_n     = idx;
    set_en    = 1'b0;
    clr_en    = 1'b0;
    clear_all = 1'b0;
    lives_dec = 1'b0;
    case (state)
      S_INIT:         if (tick) begin
                        state_n   = S_POPULATE;
                        idx_n     = '0;
                        clear_all = 1'b1;
                      end
      S_POPULATE:     if (fire) begin
                        set_en = 1'b1;
                        if (idx == LAST_IDX) state_n = S_LOOP_RESET;
                        else                 idx_n   = idx + IDX_W'(1);
                      end
      S_LOOP_RESET:   if (tick) state_n = S_MOVE_PADDLE;
      S_MOVE_PADDLE:  if (tick) state_n = S_ERASE_PADDLE;
      S_ERASE_PADDLE: if (fire) state_n = S_DRAW_PADDLE;
      S_DRAW_PADDLE:  if (fire) state_n = S_MOVE_BALL;
      S_MOVE_BALL:    if (tick) state_n = S_ERASE_BALL;
      S_ERASE_BALL:   if (fire) state_n = S_DRAW_BALL;
      S_DRAW_BALL:    if (fire) state_n = S_COLLIDE;
      S_COLLIDE:      if (tick) begin
                        if (lost) begin
                          lives_dec = 1'b1;
                          state_n   = (lives == 4'd1) ? S_GAME_OVER : S_LOOP_RESET;
                        end else if (hit_ok) begin
                          state_n = S_REMOVE_BRICK;
                          idx_n   = hit_index;
                        end else begin
                          state_n = S_MOVE_PADDLE;
                        end
                      end
      S_REMOVE_BRICK: if (fire) begin
                        clr_en  = 1'b1;
                        state_n = (bricks_left == CNT_W'(1)) ? S_LEVEL_CLEAR : S_LOOP_RESET;
                      end
      S_LEVEL_CLEAR:  if (tick) state_n = S_INIT;
      S_GAME_OVER:    state_n = S_GAME_OVER;
      default:        state_n = S_INIT;
    endcase
  end

  brick_tracker #(.NUM_BRICKS(NUM_BRICKS), .IDX_W(IDX_W), .CNT_W(CNT_W)) u_bricks (
    .clk         (clk),
    .reset       (reset),
    .clear_all   (clear_all),
    .set_en      (set_en),
    .clr_en      (clr_en),
    .idx         (idx),
    .brick_alive (brick_alive),
    .bricks_left (bricks_left)
  );

  always_comb begin
    case (state)
      S_POPULATE:     dif.draw_op = OP_POPULATE;
      S_ERASE_PADDLE: dif.draw_op = OP_ERASE_PADDLE;
      S_DRAW_PADDLE:  dif.draw_op = OP_DRAW_PADDLE;
      S_ERASE_BALL:   dif.draw_op = OP_ERASE_BALL;
      S_DRAW_BALL:    dif.draw_op = OP_DRAW_BALL;
      S_REMOVE_BRICK: dif.draw_op = OP_REMOVE_BRICK;
      default:        dif.draw_op = OP_NONE;
    endcase
  end

  assign dif.draw_req  = is_draw;
  assign dif.draw_idx  = (state == S_POPULATE || state == S_REMOVE_BRICK) ? idx : '0;
  assign move_paddle   = (state == S_MOVE_PADDLE);
  assign move_ball     = (state == S_MOVE_BALL);
  assign collide       = (state == S_COLLIDE);
  assign reset_loop    = (state == S_LOOP_RESET);
  // Masked while reset is held so every strobe reads 0 during reset.
  assign reset_initial = (state == S_INIT) & ~reset;
  assign state_out     = state;
endmodule
